// File: rtl/mult_seq.sv
// -----------------------------------------------------------------------------
// mult_seq - sequential signed 16x16 multiplier, responder side of the
// req/ack/result_rdy multiplier protocol.
//
// On a request in IDLE the operands and their parity bits are captured and
// acknowledged with a one-cycle ack pulse. A 16-step shift-add datapath then
// multiplies the operand magnitudes, and the sign is applied on the way out.
// The product is presented with its even parity and a one-cycle result_rdy.
//
// Optional feature macro: MULT_PARITY_CHECK_EN
//   defined     - operand parity is checked; a bad operand parity skips the
//                 calculation and reports arg_parity_error with a zero result.
//   not defined - operand parity bits are ignored, arg_parity_error stays 0.
//
// Ports:
//   clk              in   1  clock, rising edge
//   rst_n            in   1  asynchronous active-low reset
//   arg_a            in  16  signed operand A
//   arg_a_parity     in   1  even parity of arg_a
//   arg_b            in  16  signed operand B
//   arg_b_parity     in   1  even parity of arg_b
//   req              in   1  request level, sampled in IDLE
//   ack              out  1  operands captured, one-cycle pulse
//   result           out 32  signed product, held until next result_rdy
//   result_parity    out  1  ^result, held with result
//   result_rdy       out  1  result valid, one-cycle pulse
//   arg_parity_error out  1  operand parity was invalid, held with result
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for req; outputs hold
// CALC  | 16 shift-add steps on captured magnitudes
// DONE  | one cycle: apply sign, register result, pulse result_rdy
// -----------------------------------------------------------------------------
module mult_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] arg_a,
    input  logic        arg_a_parity,
    input  logic [15:0] arg_b,
    input  logic        arg_b_parity,
    input  logic        req,
    output logic        ack,
    output logic [31:0] result,
    output logic        result_parity,
    output logic        result_rdy,
    output logic        arg_parity_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  step_cnt;
    logic [31:0] mcand;      // multiplicand magnitude, shifts left each step
    logic [15:0] mplier;     // multiplier magnitude, shifts right each step
    logic [31:0] acc;
    logic        neg_q;      // operand signs differ
    logic        perr_q;     // captured parity verdict

    logic        accept;
    logic        par_err;
    logic [15:0] mag_a;
    logic [15:0] mag_b;
    logic [31:0] product;

`ifdef MULT_PARITY_CHECK_EN
    assign par_err = (arg_a_parity != ^arg_a) || (arg_b_parity != ^arg_b);
`else
    logic unused_parity;
    assign unused_parity = arg_a_parity ^ arg_b_parity;
    assign par_err       = 1'b0;
`endif

    // Two's-complement magnitude; -32768 maps to 16'h8000, which is exactly
    // 32768 when read as unsigned, so no extra bit is needed.
    assign mag_a   = arg_a[15] ? (~arg_a + 16'd1) : arg_a;
    assign mag_b   = arg_b[15] ? (~arg_b + 16'd1) : arg_b;
    assign accept  = (state == IDLE) && req;
    assign product = neg_q ? (~acc + 32'd1) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = par_err ? DONE : CALC;
                end
            end
            CALC: begin
                if (step_cnt == 4'd15) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt         <= 4'd0;
            mcand            <= 32'd0;
            mplier           <= 16'd0;
            acc              <= 32'd0;
            neg_q            <= 1'b0;
            perr_q           <= 1'b0;
            ack              <= 1'b0;
            result           <= 32'd0;
            result_parity    <= 1'b0;
            result_rdy       <= 1'b0;
            arg_parity_error <= 1'b0;
        end else begin
            ack        <= accept;
            result_rdy <= (state == DONE);
            case (state)
                IDLE: begin
                    if (req) begin
                        mcand    <= {16'd0, mag_a};
                        mplier   <= mag_b;
                        acc      <= 32'd0;
                        step_cnt <= 4'd0;
                        neg_q    <= arg_a[15] ^ arg_b[15];
                        perr_q   <= par_err;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand    <= {mcand[30:0], 1'b0};
                    mplier   <= {1'b0, mplier[15:1]};
                    step_cnt <= step_cnt + 4'd1;
                end
                DONE: begin
                    if (perr_q) begin
                        result           <= 32'd0;
                        result_parity    <= 1'b0;
                        arg_parity_error <= 1'b1;
                    end else begin
                        result           <= product;
                        result_parity    <= ^product;
                        arg_parity_error <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

    logic        clk;
    logic        rst_n;
    logic [15:0] arg_a;
    logic        arg_a_parity;
    logic [15:0] arg_b;
    logic        arg_b_parity;
    logic        req;
    logic        ack;
    logic [31:0] result;
    logic        result_parity;
    logic        result_rdy;
    logic        arg_parity_error;

    int total;
    int bad;

    mult_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .arg_a            (arg_a),
        .arg_a_parity     (arg_a_parity),
        .arg_b            (arg_b),
        .arg_b_parity     (arg_b_parity),
        .req              (req),
        .ack              (ack),
        .result           (result),
        .result_parity    (result_parity),
        .result_rdy       (result_rdy),
        .arg_parity_error (arg_parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // n counts rising edges since the accept edge, observed at negedges:
    // n=0 is the half-cycle right after the accept edge.
    task automatic run_txn(input logic [15:0] a, input logic ap,
                           input logic [15:0] b, input logic bp,
                           input bit scramble, output int n_rdy);
        int n;
        @(negedge clk);
        arg_a = a; arg_a_parity = ap;
        arg_b = b; arg_b_parity = bp;
        req   = 1'b1;
        @(negedge clk);
        n = 0;
        chk("ack_rise", ack, 1);
        req = 1'b0;
        @(negedge clk);
        n = 1;
        chk("ack_fall", ack, 0);
        while (!result_rdy && n < 40) begin
            if (scramble) begin
                arg_a = 16'($urandom);
                arg_b = 16'($urandom);
            end
            @(negedge clk);
            n++;
        end
        n_rdy = n;
        @(negedge clk);
        chk("rdy_pulse_width", result_rdy, 0);
    endtask

    initial begin
        int n;
        int rdy_seen;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        arg_a = 16'd0; arg_a_parity = 1'b0;
        arg_b = 16'd0; arg_b_parity = 1'b0;
        req   = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_rdy", result_rdy, 0);
        chk("rst_result", result, 32'd0);
        chk("rst_rparity", result_parity, 0);
        chk("rst_perr", arg_parity_error, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 3 x 4
        run_txn(16'd3, 1'b0, 16'd4, 1'b1, 1'b0, n);
        chk("basic_latency", n, 17);
        chk("basic_result", result, 32'd12);
        chk("basic_rparity", result_parity, 0);
        chk("basic_perr", arg_parity_error, 0);

        // -1 x 1
        run_txn(16'hFFFF, 1'b0, 16'd1, 1'b1, 1'b0, n);
        chk("m1x1_latency", n, 17);
        chk("m1x1_result", result, 32'hFFFF_FFFF);
        chk("m1x1_rparity", result_parity, 0);

        // -32768 x -32768
        run_txn(16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0, n);
        chk("minxmin_result", result, 32'h4000_0000);
        chk("minxmin_rparity", result_parity, 1);

        // 32767 x -32768
        run_txn(16'h7FFF, 1'b1, 16'h8000, 1'b1, 1'b0, n);
        chk("maxxmin_result", result, 32'hC000_8000);
        chk("maxxmin_rparity", result_parity, 1);

        // bad parity on a=5
        run_txn(16'd5, 1'b1, 16'd2, 1'b1, 1'b0, n);
`ifdef MULT_PARITY_CHECK_EN
        chk("perr_latency", n, 1);
        chk("perr_result", result, 32'd0);
        chk("perr_rparity", result_parity, 0);
        chk("perr_flag", arg_parity_error, 1);
`else
        chk("noperr_latency", n, 17);
        chk("noperr_result", result, 32'd10);
        chk("noperr_rparity", result_parity, 0);
        chk("noperr_flag", arg_parity_error, 0);
`endif

        // operands scrambled during CALC: 123 x -45 = -5535
        run_txn(16'd123, 1'b0, 16'hFFD3, 1'b1, 1'b1, n);
        chk("stable_latency", n, 17);
        chk("stable_result", result, 32'hFFFF_EA61);
        chk("stable_rparity", result_parity, 0);

        // reset mid-operation (7 x 9, reset at step 8)
        @(negedge clk);
        arg_a = 16'd7; arg_a_parity = 1'b1;
        arg_b = 16'd9; arg_b_parity = 1'b0;
        req   = 1'b1;
        @(negedge clk);
        chk("rstmid_ack", ack, 1);
        req = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_result", result, 32'd0);
        chk("rstmid_rdy", result_rdy, 0);
        chk("rstmid_ack_low", ack, 0);
        chk("rstmid_perr", arg_parity_error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (result_rdy) rdy_seen++;
        end
        chk("rstmid_no_rdy", rdy_seen, 0);
        run_txn(16'd2, 1'b1, 16'd3, 1'b0, 1'b0, n);
        chk("after_rst_latency", n, 17);
        chk("after_rst_result", result, 32'd6);

        // back-to-back with req held: 10 x -3, then -6 x -6
        @(negedge clk);
        arg_a = 16'd10;   arg_a_parity = 1'b0;
        arg_b = 16'hFFFD; arg_b_parity = 1'b1;
        req   = 1'b1;
        @(negedge clk);
        n = 0;
        chk("b2b_ack1", ack, 1);
        arg_a = 16'hFFFA; arg_a_parity = 1'b0;
        arg_b = 16'hFFFA; arg_b_parity = 1'b0;
        while (!result_rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_rdy1_latency", n, 17);
        chk("b2b_result1", result, 32'hFFFF_FFE2);
        chk("b2b_rparity1", result_parity, 0);
        @(negedge clk);
        n++;
        chk("b2b_ack2", ack, 1);
        chk("b2b_rdy1_fall", result_rdy, 0);
        req = 1'b0;
        while (!result_rdy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_rdy2_latency", n, 35);
        chk("b2b_result2", result, 32'd36);
        chk("b2b_rparity2", result_parity, 0);
        @(negedge clk);
        chk("b2b_rdy2_fall", result_rdy, 0);
        chk("b2b_no_third_ack", ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
# mult_seq

Sequential signed 16×16 multiplier: the responder side of the req/ack/result_rdy multiplier protocol driven by the team's testbench BFM. It captures two parity-protected operands on a request and acknowledges them. It computes the 32-bit signed product with a 16-step shift-add datapath, then presents the result with parity and a one-cycle ready strobe. It sits directly under the lab testbench as the DUT.

## Interface
- No parameters; widths are fixed (16-bit operands, 32-bit result).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low; outputs at reset values while low.
- arg_a  input  16  signed operand A (two's complement).
- arg_a_parity  input  1  even-parity bit for arg_a; valid value = ^arg_a.
- arg_b  input  16  signed operand B.
- arg_b_parity  input  1  even-parity bit for arg_b; valid value = ^arg_b.
- req  input  1  request; level, sampled on rising clk.
- ack  output  1  operands captured; one-cycle pulse.
- result  output  32  signed product; held until next result_rdy.
- result_parity  output  1  ^result; held with result.
- result_rdy  output  1  result valid; one-cycle pulse.
- arg_parity_error  output  1  1 if either operand parity invalid; held with result.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: if req=1 at edge E0:
  - capture arg_a, arg_b and parity bits;
  - set ack=1 for the cycle after E0;
  - go to CALC, or to DONE when parity is invalid.
- IDLE with req=0: no change; all outputs hold.
- CALC: operates on captured operand magnitudes, each 16-bit unsigned (|−32768| = 32768 fits).
  - Each edge performs one step: conditional add of the multiplicand magnitude into a 32-bit accumulator on the multiplier LSB, then shift.
  - A 4-bit step counter runs 0..15. At the step with counter=15, go to DONE.
- DONE (one cycle): product = accumulator, negated if the operand signs differ.
  - Register result, result_parity = ^result, arg_parity_error=0, result_rdy=1.
  - Return to IDLE.
- Parity-error path:
  - result=0, result_parity=0, arg_parity_error=1, result_rdy=1.
  - No CALC.
- Full range is exact: −32768 × −32768 = 0x4000_0000; no overflow is possible.
- Operand inputs are ignored after capture; changing them during CALC has no effect.
- req is ignored outside IDLE.
  - If req is still high when the FSM returns to IDLE, a new transaction is accepted on that edge.
  - The initiator deasserts req after ack; holding req gives back-to-back operation.
- Async reset at any time, including mid-CALC: FSM to IDLE, counter and accumulator to 0, transaction discarded, no result_rdy.

## Timing
- Reset values: ack=0, result_rdy=0, result=0, result_parity=0, arg_parity_error=0.
- All outputs are registered.
- ack: high for exactly one cycle, from edge E0 to edge E0+1.
- Normal latency: result_rdy high from edge E0+17 to E0+18.
  - That is 16 CALC cycles plus DONE, measured from the accept edge.
- Parity-error latency: result_rdy high from edge E0+1 to E0+2.
- result, result_parity and arg_parity_error update on the same edge result_rdy rises.
  - They stay stable until the next result_rdy.
- Minimum transaction spacing with req held: 18 cycles normal, 2 cycles error.
- ack and result_rdy are never high in the same cycle.

## Configuration
- MULT_PARITY_CHECK_EN defined:
  - operand parity is checked as above;
  - invalid parity takes the error path.
- Not defined:
  - arg_a_parity and arg_b_parity are ignored;
  - arg_parity_error is constant 0;
  - every request takes the normal CALC path;
  - result_parity is still generated.

## Test plan
- Basic product: a=3, b=4, valid parity, req pulse until ack.
  - ack 1 cycle after accept; result_rdy 17 cycles after accept.
  - result=12, result_parity=0, arg_parity_error=0.
- Sign and extremes:
  - −1×1 gives result=0xFFFF_FFFF, parity 0.
  - −32768×−32768 gives 0x4000_0000, parity 1.
  - 32767×−32768 gives 0xC000_8000, parity 1.
- Parity error (MULT_PARITY_CHECK_EN defined): a=5 with arg_a_parity=1, b=2 valid.
  - result_rdy 1 cycle after accept; arg_parity_error=1, result=0, result_parity=0.
  - Same stimulus with the macro undefined: result=10, arg_parity_error=0.
- Reset mid-operation: accept a=7, b=9; drop rst_n for 1 cycle at step 8.
  - All outputs go to 0 immediately; no result_rdy.
  - A new request a=2, b=3 afterwards yields 6 with normal latency.
- Back-to-back: req held high for two transactions (a=10, b=−3, then a=−6, b=−6).
  - Results −30 then 36; second ack on the edge after the first result_rdy.
  - result_rdy pulses exactly 18 cycles apart.
- Operand stability: change arg_a/arg_b every cycle during CALC.
  - Result equals the product of the captured values only.
